// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_LD   = 2'd1;
    localparam logic [1:0] GNT_DM   = 2'd2;
    localparam logic [1:0] GNT_IM   = 2'd3;

    // rr_ptr encoding: which of DM/IM wins the next contention
    localparam logic RR_DM = 1'b0;
    localparam logic RR_IM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes, BRAM port and status of the arbiter, bundled as one interface.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              ld_req, dm_req, im_req;
    logic              ld_we, dm_we;
    logic [ADDR_W-1:0] ld_addr, dm_addr, im_addr;
    logic [DATA_W-1:0] ld_wdata, dm_wdata;
    logic              ld_ack, dm_ack, im_ack;
    logic [DATA_W-1:0] rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;
    logic [1:0]        gnt_id;

    modport slave (
        input  ld_req, dm_req, im_req, ld_we, dm_we,
        input  ld_addr, dm_addr, im_addr, ld_wdata, dm_wdata, ram_dout,
        output ld_ack, dm_ack, im_ack, rdata,
        output ram_en, ram_we, ram_addr, ram_din, busy, gnt_id
    );

    modport master (
        output ld_req, dm_req, im_req, ld_we, dm_we,
        output ld_addr, dm_addr, im_addr, ld_wdata, dm_wdata, ram_dout,
        input  ld_ack, dm_ack, im_ack, rdata,
        input  ram_en, ram_we, ram_addr, ram_din, busy, gnt_id
    );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: loader first, then DM/IM by round-robin pointer.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ld_req,
    input  logic       dm_req,
    input  logic       im_req,
    input  logic       rr_ptr,
    output logic [1:0] winner
);
    always_comb begin
        winner = GNT_NONE;
        if (ld_req) begin
            winner = GNT_LD;
        end else if (dm_req && im_req) begin
            winner = (rr_ptr == RR_IM) ? GNT_IM : GNT_DM;
        end else if (dm_req) begin
            winner = GNT_DM;
        end else if (im_req) begin
            winner = GNT_IM;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between loader (LD), data (DM) and fetch (IM) requesters,
// hiding the BRAM read latency behind a per-requester req/ack handshake.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              we_q, we_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ld_ack_q, ld_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              im_ack_q, im_ack_d;
    logic              busy_q, busy_d;
    logic [1:0]        winner;
    logic              ack_now;

    arb_pick u_pick (
        .ld_req (bus.ld_req),
        .dm_req (bus.dm_req),
        .im_req (bus.im_req),
        .rr_ptr (rr_q),
        .winner (winner)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        we_d       = we_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (winner != GNT_NONE) begin
                    state_d  = ISSUE;
                    gnt_d    = winner;
                    ram_en_d = 1'b1;
                    case (winner)
                        GNT_LD: begin
                            we_d       = bus.ld_we;
                            ram_addr_d = bus.ld_addr;
                            ram_din_d  = bus.ld_wdata;
                        end
                        GNT_DM: begin
                            we_d       = bus.dm_we;
                            ram_addr_d = bus.dm_addr;
                            ram_din_d  = bus.dm_wdata;
                            rr_d       = RR_IM;
                        end
                        default: begin
                            we_d       = 1'b0;
                            ram_addr_d = bus.im_addr;
                            ram_din_d  = '0;
                            rr_d       = RR_DM;
                        end
                    endcase
                    ram_we_d = we_d;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            WAIT: begin
                // terminal count marks the cycle in which ram_dout carries the word
                if (cnt_q == 2'd0) begin
                    rdata_d = bus.ram_dout;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase

        // RESP is only ever entered for one cycle, so this yields a single-cycle pulse
        ack_now  = (state_d == RESP);
        ld_ack_d = ack_now && (gnt_q == GNT_LD);
        dm_ack_d = ack_now && (gnt_q == GNT_DM);
        im_ack_d = ack_now && (gnt_q == GNT_IM);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= RR_DM;
            we_q       <= 1'b0;
            gnt_q      <= GNT_NONE;
            cnt_q      <= 2'd0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rdata_q    <= '0;
            ld_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            im_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            we_q       <= we_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rdata_q    <= rdata_d;
            ld_ack_q   <= ld_ack_d;
            dm_ack_q   <= dm_ack_d;
            im_ack_q   <= im_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ram_en   = ram_en_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.rdata    = rdata_q;
    assign bus.ld_ack   = ld_ack_q;
    assign bus.dm_ack   = dm_ack_q;
    assign bus.im_ack   = im_ack_q;
    assign bus.busy     = busy_q;
    assign bus.gnt_id   = gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus scoreboard of expected acks, with
// hand-written sequences for round-robin, loader priority, reset abort and RD_LAT=3.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    // BRAM models; the read pipeline carries a poison word when no read was issued
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem3 [0:(1<<AW)-1];
    logic [DW-1:0] p1, p3a, p3b, p3c;

    always @(posedge clk) begin
        if (bus1.ram_en && bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_din;
        p1 <= (bus1.ram_en && !bus1.ram_we) ? mem1[bus1.ram_addr] : 32'hBAD1BAD1;
    end
    always @(posedge clk) begin
        if (bus3.ram_en && bus3.ram_we) mem3[bus3.ram_addr] <= bus3.ram_din;
        p3a <= (bus3.ram_en && !bus3.ram_we) ? mem3[bus3.ram_addr] : 32'hBAD3BAD3;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign bus1.ram_dout = p1;
    assign bus3.ram_dout = p3c;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [1:0]    id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] rd, input int c);
        exp_t e;
        e.id = id; e.rdata = rd; e.cyc = c;
        sbq.push_back(e);
    endtask

    function automatic logic ack_of(input logic [1:0] id);
        case (id)
            GNT_LD:  return bus1.ld_ack;
            GNT_DM:  return bus1.dm_ack;
            default: return bus1.im_ack;
        endcase
    endfunction

    task automatic set_req(input logic [1:0] id, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (id)
            GNT_LD: begin
                bus1.ld_req = v; bus1.ld_we = we; bus1.ld_addr = a; bus1.ld_wdata = d;
            end
            GNT_DM: begin
                bus1.dm_req = v; bus1.dm_we = we; bus1.dm_addr = a; bus1.dm_wdata = d;
            end
            default: begin
                bus1.im_req = v; bus1.im_addr = a;
            end
        endcase
    endtask

    task automatic wait_ack(input logic [1:0] id, input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ack_of(id) && t < 40);
            chk("ack_seen", ack_of(id), 1'b1);
        end
    endtask

    // holds req through n acks, drops it in the cycle after the last one
    task automatic drive(input logic [1:0] id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int n, input int dly);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
        end
        set_req(id, 1'b1, we, a, d);
        wait_ack(id, n);
        @(posedge clk);
        #1;
        set_req(id, 1'b0, we, a, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            logic [2:0] acks;
            logic [1:0] aid;
            exp_t e;
            acks = {bus1.ld_ack, bus1.dm_ack, bus1.im_ack};
            if (acks != 3'b000) begin
                aid = bus1.ld_ack ? GNT_LD : (bus1.dm_ack ? GNT_DM : GNT_IM);
                chk("ack_onehot", 32'($countones(acks)), 32'd1);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", acks, 3'b000);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_id", aid, e.id);
                    chk("ack_gnt_id", bus1.gnt_id, e.id);
                    chk("ack_rdata", bus1.rdata, e.rdata);
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;

        rst = 1'b1;
        bus1.ld_req = 0; bus1.dm_req = 0; bus1.im_req = 0;
        bus1.ld_we = 0; bus1.dm_we = 0;
        bus1.ld_addr = '0; bus1.dm_addr = '0; bus1.im_addr = '0;
        bus1.ld_wdata = '0; bus1.dm_wdata = '0;
        bus3.ld_req = 0; bus3.dm_req = 0; bus3.im_req = 0;
        bus3.ld_we = 0; bus3.dm_we = 0;
        bus3.ld_addr = '0; bus3.dm_addr = '0; bus3.im_addr = '0;
        bus3.ld_wdata = '0; bus3.dm_wdata = '0;

        vecs[0] = '{GNT_LD, 1'b1, 10'h3FF, 32'hA5A5A5A5, 2, 32'hDEADBEEF};
        vecs[1] = '{GNT_LD, 1'b0, 10'h3FF, 32'h0,        3, 32'hA5A5A5A5};
        vecs[2] = '{GNT_DM, 1'b1, 10'h000, 32'h00000001, 2, 32'hA5A5A5A5};
        vecs[3] = '{GNT_IM, 1'b0, 10'h005, 32'h0,        3, 32'hDEADBEEF};
        vecs[4] = '{GNT_DM, 1'b0, 10'h000, 32'h0,        3, 32'h00000001};
        vecs[5] = '{GNT_IM, 1'b0, 10'h3FF, 32'h0,        3, 32'hA5A5A5A5};
        vecs[6] = '{GNT_DM, 1'b1, 10'h005, 32'hFFFFFFFF, 2, 32'hA5A5A5A5};
        vecs[7] = '{GNT_LD, 1'b0, 10'h005, 32'h0,        3, 32'hFFFFFFFF};
        vecs[8] = '{GNT_IM, 1'b0, 10'h000, 32'h0,        3, 32'h00000001};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_en",   bus1.ram_en,   1'b0);
        chk("rst_ram_we",   bus1.ram_we,   1'b0);
        chk("rst_ram_addr", bus1.ram_addr, 10'h0);
        chk("rst_ram_din",  bus1.ram_din,  32'h0);
        chk("rst_rdata",    bus1.rdata,    32'h0);
        chk("rst_busy",     bus1.busy,     1'b0);
        chk("rst_gnt_id",   bus1.gnt_id,   GNT_NONE);
        chk("rst_acks",     {bus1.ld_ack, bus1.dm_ack, bus1.im_ack}, 3'b000);

        // single DM write, then read back
        @(posedge clk); #1; base = cyc;
        push(GNT_DM, 32'h0, base + 2);
        set_req(GNT_DM, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
        @(negedge clk);
        chk("w_c0_busy", bus1.busy, 1'b0);
        @(negedge clk);
        chk("w_c1_ram_en",   bus1.ram_en,   1'b1);
        chk("w_c1_ram_we",   bus1.ram_we,   1'b1);
        chk("w_c1_ram_addr", bus1.ram_addr, 10'h005);
        chk("w_c1_ram_din",  bus1.ram_din,  32'hDEADBEEF);
        chk("w_c1_gnt_id",   bus1.gnt_id,   GNT_DM);
        wait_ack(GNT_DM, 1);
        @(posedge clk); #1;
        set_req(GNT_DM, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF);

        @(posedge clk); #1; base = cyc;
        push(GNT_DM, 32'hDEADBEEF, base + 3);
        drive(GNT_DM, 1'b0, 10'h005, 32'h0, 1, 0);
        @(negedge clk);
        chk("idle_after_read_gnt", bus1.gnt_id, GNT_NONE);

        // table of single transactions
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1; base = cyc;
            push(vecs[i].id, vecs[i].exp_rdata, base + vecs[i].lat);
            drive(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1, 0);
        end

        // round-robin from reset: DM, IM, DM, IM
        do_reset();
        @(posedge clk); #1; base = cyc;
        push(GNT_DM, 32'h0,       base + 2);
        push(GNT_IM, 32'h11112222, base + 6);
        push(GNT_DM, 32'h11112222, base + 9);
        push(GNT_IM, 32'h11112222, base + 13);
        fork
            drive(GNT_DM, 1'b1, 10'h020, 32'h11112222, 2, 0);
            drive(GNT_IM, 1'b0, 10'h020, 32'h0, 2, 0);
        join

        // loader priority; DM grant first leaves rr_ptr pointing at IM
        @(posedge clk); #1; base = cyc;
        push(GNT_DM, 32'h11112222, base + 2);
        drive(GNT_DM, 1'b1, 10'h042, 32'h42424242, 1, 0);
        @(posedge clk); #1; base = cyc;
        push(GNT_IM, 32'h11112222, base + 3);
        push(GNT_LD, 32'h11112222, base + 6);
        push(GNT_DM, 32'h11112222, base + 9);
        push(GNT_IM, 32'hCAFEF00D, base + 13);
        fork
            begin
                drive(GNT_IM, 1'b0, 10'h020, 32'h0, 1, 0);
                drive(GNT_IM, 1'b0, 10'h040, 32'h0, 1, 1);
            end
            drive(GNT_LD, 1'b1, 10'h040, 32'hCAFEF00D, 1, 2);
            drive(GNT_DM, 1'b1, 10'h041, 32'h0BADF00D, 1, 2);
        join

        // reset in the WAIT cycle of a read aborts it
        @(posedge clk); #1;
        set_req(GNT_DM, 1'b1, 1'b0, 10'h005, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_ram_en",   bus1.ram_en,   1'b0);
        chk("abort_ram_addr", bus1.ram_addr, 10'h0);
        chk("abort_rdata",    bus1.rdata,    32'h0);
        chk("abort_busy",     bus1.busy,     1'b0);
        chk("abort_gnt_id",   bus1.gnt_id,   GNT_NONE);
        chk("abort_dm_ack",   bus1.dm_ack,   1'b0);
        set_req(GNT_DM, 1'b0, 1'b0, 10'h005, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_ack_busy", bus1.busy, 1'b0);
        @(posedge clk); #1; base = cyc;
        push(GNT_DM, 32'hFFFFFFFF, base + 3);
        drive(GNT_DM, 1'b0, 10'h005, 32'h0, 1, 0);

        // RD_LAT = 3: preload via a write, then an IM read
        @(posedge clk); #1; base = cyc;
        bus3.dm_req = 1; bus3.dm_we = 1; bus3.dm_addr = 10'h123; bus3.dm_wdata = 32'h12345678;
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus3.dm_ack && t < 40);
            chk("l3_preload_cycle", cyc, base + 2);
        end
        @(posedge clk); #1;
        bus3.dm_req = 0;
        @(posedge clk); #1; base = cyc;
        bus3.im_req = 1; bus3.im_addr = 10'h123;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("l3_busy_c%0d", c), bus3.busy, (c >= 1 && c <= 5));
            chk($sformatf("l3_ack_c%0d", c), bus3.im_ack, (c == 5));
            if (c == 5) begin
                chk("l3_rdata", bus3.rdata, 32'h12345678);
                @(posedge clk); #1;
                bus3.im_req = 0;
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port instruction/data block RAM between three requesters: the boot loader (LD), the MEM-phase load/store path (DM) and the IF-phase fetch path (IM). The loader has absolute priority; DM and IM alternate round-robin. It sits between the multi-cycle control unit's datapath and the BRAM, and it hides the BRAM read latency behind a per-requester req/ack handshake.

## Interface
- ADDR_W, 10, word-address width
- DATA_W, 32, data width
- RD_LAT, 1, BRAM read latency in cycles; legal range 1..3
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_req / dm_req / im_req  in  1 each  request, held until ack
- ld_we / dm_we  in  1 each  1 = write, 0 = read; IM is read-only
- ld_addr / dm_addr / im_addr  in  ADDR_W each  word address, held with req
- ld_wdata / dm_wdata  in  DATA_W each  write data, held with req
- ld_ack / dm_ack / im_ack  out  1 each  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid in the ack cycle of a read
- ram_en  out  1  BRAM enable
- ram_we  out  1  BRAM write enable
- ram_addr  out  ADDR_W  BRAM address
- ram_din  out  DATA_W  BRAM write data
- ram_dout  in  DATA_W  BRAM read data, RD_LAT cycles after the enable edge
- busy  out  1  high in every state except IDLE
- gnt_id  out  2  granted requester: 0 none, 1 LD, 2 DM, 3 IM

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick a winner and latch its we, addr and wdata; go to ISSUE.
  - Pick order: ld_req first. Otherwise choose between DM and IM with the rr_ptr.
  - rr_ptr points at the requester preferred on the next DM/IM contention. It flips to the other one after each DM or IM grant. LD grants do not change it.
- ISSUE:
  - ram_en = 1, ram_addr and ram_din from the latch, ram_we = latched we.
  - Writes go to RESP. Reads go to WAIT.
- WAIT:
  - Lasts RD_LAT cycles, counted by a 2-bit counter.
  - In the last WAIT cycle, ram_dout is captured into rdata. Then go to RESP.
- RESP:
  - Assert the granted requester's ack for exactly one cycle. Go to IDLE.
- rdata holds its value until the next read capture. Writes do not change rdata.
- Requester rules:
  - addr, we and wdata stay stable from req rise until ack.
  - A requester with nothing more to do drops req in the cycle after its ack.
  - Keeping req high after ack is treated as a new transaction.
- Dropping req before ack is illegal. The arbiter completes the transaction anyway, and a write is still committed.
- There is no preemption: an LD request arriving mid-transaction waits for the next IDLE.
- An IM request with im_we absent is always a read.

## Timing
- All outputs are registered.
- Reset values: ram_en, ram_we and every ack = 0; ram_addr, ram_din and rdata = 0; busy = 0; gnt_id = 0; state IDLE; rr_ptr = DM.
- Reset mid-transaction aborts the transaction immediately. An unfinished write may or may not have reached the BRAM. No ack is issued.
- Write latency: req high in cycle 0 → ram_en/ram_we high in cycle 1 → ack in cycle 2.
- Read latency: req high in cycle 0 → ram_en in cycle 1 → WAIT in cycles 2..1+RD_LAT → ack and rdata in cycle 2+RD_LAT. For RD_LAT = 1, the ack is in cycle 3.
- Throughput: one transaction per 3 cycles (write) or 3+RD_LAT cycles (read), because of the mandatory IDLE slot.
- gnt_id is valid from ISSUE through RESP, and 0 in IDLE.
- Simultaneous DM and IM requests from reset: DM is served first. IM wins the next contention.

## Structure
- Package mem_arb_pkg:
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - Requester ID constants: GNT_NONE = 0, GNT_LD = 1, GNT_DM = 2, GNT_IM = 3.
- One combinational sub-module, arb_pick: inputs ld_req, dm_req, im_req and rr_ptr; output a 2-bit winner ID.
- The FSM, request latch, WAIT counter and output registers live in mem_port_arbiter.

## Test plan
- **Reset mid-read:** start a read, assert rst during WAIT → all outputs 0 at once; no ack; next request completes normally.
- **Single DM write then read:** dm write addr 0x005, data 0xDEADBEEF → dm_ack in cycle 2. Then dm read of 0x005 → dm_ack in cycle 3 with rdata = 0xDEADBEEF (RD_LAT = 1).
- **Round-robin:** dm_req and im_req both held high continuously from reset → grant order DM, IM, DM, IM, each completing with its own ack.
- **Loader priority:** ld_req rises during an IM read's WAIT → the IM read completes, then LD is granted ahead of a pending DM; rr_ptr is unchanged.
- **RD_LAT = 3:** IM read of a preloaded 0x12345678 → im_ack in cycle 5 with rdata = 0x12345678; busy high in cycles 1..5.
